ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch front-end that acts as the read initiator for the synchronous-read instruction ROM (EN plus registered word address, data valid one cycle later). It keeps the fetch PC and issues one ROM read per cycle. It hands each instruction word and its PC to the decode stage over a valid/ready handshake, and accepts branch/jump redirects from execute. Stalls are absorbed by deasserting ROM_EN, because the ROM holds its registered address and therefore its output word.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; must be word-aligned.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; synchronous, active-high
- ROM_EN  out  1  ROM read strobe; ROM latches ROM_ADDR[9:2] at the edge where this is 1
- ROM_ADDR  out  32  ROM byte address; bits [1:0] always 0
- ROM_DOUT  in  32  ROM word for the address latched at the previous enabled edge
- IR_VALID  out  1  instruction word available to decode
- IR_READY  in  1  decode accepts the word this cycle
- IR_DATA  out  32  instruction word; combinational pass-through of ROM_DOUT
- IR_PC  out  32  byte address of IR_DATA
- REDIRECT  in  1  single-cycle request to restart fetch at REDIRECT_PC
- REDIRECT_PC  in  32  redirect target (byte address)
- HALT  in  1  level; while 1, no new sequential fetches are issued
- MISALIGN  out  1  sticky; a redirect target had nonzero bits [1:0]
- FETCH_CNT  out  32  words handed to decode (FETCH_PERF_EN only)
- STALL_CNT  out  32  cycles with IR_VALID=1 and IR_READY=0 (FETCH_PERF_EN only)

## Operation
- State registers:
  - FETCH_PC: next sequential address.
  - RESP_V / RESP_PC: a word is in flight or held at the ROM output, and its PC.
  - MISALIGN.
  - Performance counters.
- Derived signals:
  - advance = !RESP_V || IR_READY
  - ROM_ADDR = REDIRECT ? {REDIRECT_PC[31:2],2'b00} : FETCH_PC
  - ROM_EN = !RST && (REDIRECT || (advance && !HALT))
  - IR_VALID = RESP_V && !REDIRECT
  - IR_PC = RESP_PC
- Edge update, priority top-down:
  - RST: FETCH_PC<=RESET_PC; RESP_V<=0; RESP_PC<=0; MISALIGN<=0; counters<=0.
  - ROM_EN=1: RESP_V<=1; RESP_PC<=ROM_ADDR; FETCH_PC<=ROM_ADDR+4.
  - advance=1 (HALT, slot empty or consumed): RESP_V<=0.
  - otherwise: hold all state. ROM_EN=0 keeps the ROM address latched, so ROM_DOUT stays stable.
- Redirect:
  - Overrides HALT and stall.
  - The word presented in the redirect cycle is discarded: IR_VALID is forced 0, so no handshake occurs.
  - The target is fetched in the same cycle.
- MISALIGN <= 1 when REDIRECT=1 and REDIRECT_PC[1:0]!=0. The fetch still proceeds at the aligned address.
- Address arithmetic is 32-bit modulo 2^32. The ROM decodes only [9:2], so fetch beyond 1 KiB aliases; no fault is raised.

## Timing
- Reset values: ROM_EN=0, ROM_ADDR=RESET_PC, IR_VALID=0, IR_PC=0, MISALIGN=0, FETCH_CNT=0, STALL_CNT=0.
- First cycle after RST falls: ROM_EN=1, ROM_ADDR=RESET_PC. Next cycle: IR_VALID=1, IR_PC=RESET_PC.
- Latency is one cycle from ROM_EN edge to IR_VALID. With IR_READY held at 1, throughput is one word per cycle.
- Redirect-to-valid target is one cycle: REDIRECT at cycle n gives IR_PC=target, IR_VALID=1 at n+1.
- REDIRECT→ROM_EN/ROM_ADDR/IR_VALID is a combinational path. It is the critical path to constrain.
- Decode must not make IR_READY depend combinationally on REDIRECT.
- HALT asserted: the held word is still delivered. Afterwards IR_VALID=0 and FETCH_PC is retained. Deasserting HALT resumes at FETCH_PC.
- Reset mid-stall or mid-redirect: RST wins; all in-flight state is dropped.

## Configuration
- FETCH_PERF_EN defined:
  - FETCH_CNT increments on each IR_VALID&&IR_READY edge.
  - STALL_CNT increments on each IR_VALID&&!IR_READY edge.
  - Both wrap at 2^32 and clear on RST.
- FETCH_PERF_EN undefined: counter registers are not built; FETCH_CNT and STALL_CNT are tied to 0.

## Test plan
- Reset release with IR_READY=1 and the standard ROM image → IR_PC 0x0,0x4,0x8 on consecutive cycles with IR_DATA 0x40000113, 0xfe010113, 0x00812e23.
- IR_READY=0 for 3 cycles at IR_PC=0x8 → ROM_EN=0, IR_DATA stable at 0x00812e23. After release, next word is 0xfe010413 at 0xC. STALL_CNT=3 with FETCH_PERF_EN.
- REDIRECT with REDIRECT_PC=0x1C while IR_PC=0x10 and IR_READY=0 → no handshake for 0x10. Next cycle IR_PC=0x1C, IR_DATA=0xfec42703.
- REDIRECT_PC=0x22 → ROM_ADDR=0x20, MISALIGN=1 and held until RST.
- HALT=1 with a held word → word accepted, then IR_VALID=0 and ROM_EN=0. HALT=0 → fetch resumes at the next sequential PC.
- RST pulsed during a stall → the following cycles match the reset-release sequence exactly; counters read 0.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: ROM read port, decode handshake, redirect/halt controls and status.
// master = fetch unit side, slave = ROM/decode/execute environment side.
interface ifetch_unit_if;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_dout;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_data;
  logic [31:0] ir_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        misalign;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  modport master (
    output rom_en, rom_addr, ir_valid, ir_data, ir_pc, misalign, fetch_cnt, stall_cnt,
    input  rom_dout, ir_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  rom_en, rom_addr, ir_valid, ir_data, ir_pc, misalign, fetch_cnt, stall_cnt,
    output rom_dout, ir_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end for a sync-read ROM; optional perf counters under FETCH_PERF_EN.
// Latency: one cycle ROM_EN edge to IR_VALID; redirect target valid the next cycle.
// Backpressure: IR_READY=0 drops ROM_EN so the ROM holds its address and output word.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          CLK,
  input logic          RST,
  ifetch_unit_if.master bus
);

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic        resp_v;
  logic        misalign_q;
  logic        advance;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic        ir_valid;

  // Slot frees when empty or when decode takes the word this cycle.
  assign advance  = !resp_v || bus.ir_ready;
  assign rom_addr = bus.redirect ? {bus.redirect_pc[31:2], 2'b00} : fetch_pc;
  assign rom_en   = !RST && (bus.redirect || (advance && !bus.halt));
  assign ir_valid = resp_v && !bus.redirect;

  assign bus.rom_en   = rom_en;
  assign bus.rom_addr = rom_addr;
  assign bus.ir_valid = ir_valid;
  assign bus.ir_data  = bus.rom_dout;
  assign bus.ir_pc    = resp_pc;
  assign bus.misalign = misalign_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc   <= RESET_PC;
      resp_v     <= 1'b0;
      resp_pc    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      if (rom_en) begin
        resp_v   <= 1'b1;
        resp_pc  <= rom_addr;
        fetch_pc <= rom_addr + 32'd4;
      end else if (advance) begin
        resp_v <= 1'b0;
      end
      // Sticky until reset; the fetch itself uses the aligned address.
      if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
        misalign_q <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (ir_valid && bus.ir_ready) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (ir_valid && !bus.ir_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.fetch_cnt = fetch_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.fetch_cnt = 32'h0;
  assign bus.stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a sync-read ROM model and hand-computed expectations.
module tb_ifetch_unit;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:255];
  logic [31:0] rom_q = 32'h0;
  always @(posedge CLK) if (bus.rom_en) rom_q <= mem[bus.rom_addr[9:2]];
  assign bus.rom_dout = rom_q;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Reset release with IR_READY=1; walks the first three words and leaves pc 0x8 presented.
  task automatic test_reset;
    RST = 1'b1; bus.ir_ready = 1'b1; bus.halt = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    tick(); tick(); #1;
    checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL rst_rom_en got %b exp 0", bus.rom_en); end
    checks++; if (bus.rom_addr !== 32'h0) begin errors++; $display("FAIL rst_rom_addr got %h exp 00000000", bus.rom_addr); end
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL rst_ir_valid got %b exp 0", bus.ir_valid); end
    checks++; if (bus.ir_pc !== 32'h0) begin errors++; $display("FAIL rst_ir_pc got %h exp 00000000", bus.ir_pc); end
    checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b exp 0", bus.misalign); end
    checks++; if (bus.fetch_cnt !== 32'h0 || bus.stall_cnt !== 32'h0)
      begin errors++; $display("FAIL rst_cnt got %h/%h exp 0/0", bus.fetch_cnt, bus.stall_cnt); end
    tick(); RST = 1'b0; #1;
    checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 32'h0 || bus.ir_valid !== 1'b0)
      begin errors++; $display("FAIL rel_first got en=%b addr=%h v=%b exp 1/00000000/0", bus.rom_en, bus.rom_addr, bus.ir_valid); end
    tick(); #1;
    checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h0 || bus.ir_data !== 32'h40000113)
      begin errors++; $display("FAIL rel_w0 got v=%b pc=%h d=%h exp 1/00000000/40000113", bus.ir_valid, bus.ir_pc, bus.ir_data); end
    tick(); #1;
    checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h4 || bus.ir_data !== 32'hfe010113)
      begin errors++; $display("FAIL rel_w1 got v=%b pc=%h d=%h exp 1/00000004/fe010113", bus.ir_valid, bus.ir_pc, bus.ir_data); end
    tick(); #1;
    checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h8 || bus.ir_data !== 32'h00812e23)
      begin errors++; $display("FAIL rel_w2 got v=%b pc=%h d=%h exp 1/00000008/00812e23", bus.ir_valid, bus.ir_pc, bus.ir_data); end
  endtask

  // Three stall cycles at pc 0x8, then release; ends with pc 0xC presented.
  task automatic test_stall;
    bus.ir_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.rom_en !== 1'b0 || bus.ir_valid !== 1'b1 || bus.ir_data !== 32'h00812e23)
        begin errors++; $display("FAIL stall_%0d got en=%b v=%b d=%h exp 0/1/00812e23", i, bus.rom_en, bus.ir_valid, bus.ir_data); end
      if (i < 2) begin tick(); #1; end
    end
    tick(); bus.ir_ready = 1'b1; #1;
    checks++; if (bus.stall_cnt !== (PERF ? 32'd3 : 32'd0))
      begin errors++; $display("FAIL stall_cnt got %0d exp %0d", bus.stall_cnt, PERF ? 3 : 0); end
    checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 32'hC)
      begin errors++; $display("FAIL stall_rel got en=%b addr=%h exp 1/0000000c", bus.rom_en, bus.rom_addr); end
    tick(); #1;
    checks++; if (bus.ir_pc !== 32'hC || bus.ir_data !== 32'hfe010413)
      begin errors++; $display("FAIL stall_next got pc=%h d=%h exp 0000000c/fe010413", bus.ir_pc, bus.ir_data); end
  endtask

  // Redirect to 0x1C while 0x10 is stalled; ends with pc 0x1C presented.
  task automatic test_redirect;
    tick(); bus.ir_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h1C; #1;
    checks++; if (bus.ir_pc !== 32'h10 || bus.ir_valid !== 1'b0 || bus.rom_en !== 1'b1 || bus.rom_addr !== 32'h1C)
      begin errors++; $display("FAIL redir_cyc got pc=%h v=%b en=%b addr=%h exp 00000010/0/1/0000001c", bus.ir_pc, bus.ir_valid, bus.rom_en, bus.rom_addr); end
    tick(); bus.redirect = 1'b0; bus.ir_ready = 1'b1; #1;
    checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h1C || bus.ir_data !== 32'hfec42703)
      begin errors++; $display("FAIL redir_tgt got v=%b pc=%h d=%h exp 1/0000001c/fec42703", bus.ir_valid, bus.ir_pc, bus.ir_data); end
    checks++; if (bus.fetch_cnt !== (PERF ? 32'd4 : 32'd0))
      begin errors++; $display("FAIL fetch_cnt got %0d exp %0d", bus.fetch_cnt, PERF ? 4 : 0); end
  endtask

  // Misaligned target 0x22 while 0x20 is presented; ends with pc 0x20 (redirected) presented.
  task automatic test_misalign;
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h22; #1;
    checks++; if (bus.rom_addr !== 32'h20 || bus.misalign !== 1'b0 || bus.ir_valid !== 1'b0)
      begin errors++; $display("FAIL mis_cyc got addr=%h m=%b v=%b exp 00000020/0/0", bus.rom_addr, bus.misalign, bus.ir_valid); end
    tick(); bus.redirect = 1'b0; #1;
    checks++; if (bus.misalign !== 1'b1 || bus.ir_pc !== 32'h20 || bus.ir_data !== 32'h10000008)
      begin errors++; $display("FAIL mis_after got m=%b pc=%h d=%h exp 1/00000020/10000008", bus.misalign, bus.ir_pc, bus.ir_data); end
  endtask

  // Halt with a held word at 0x24, then resume at 0x28.
  task automatic test_halt;
    tick(); bus.ir_ready = 1'b0; bus.halt = 1'b1; #1;
    checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h24 || bus.rom_en !== 1'b0)
      begin errors++; $display("FAIL halt_held got v=%b pc=%h en=%b exp 1/00000024/0", bus.ir_valid, bus.ir_pc, bus.rom_en); end
    tick(); bus.ir_ready = 1'b1; #1;
    checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h24 || bus.rom_en !== 1'b0)
      begin errors++; $display("FAIL halt_acc got v=%b pc=%h en=%b exp 1/00000024/0", bus.ir_valid, bus.ir_pc, bus.rom_en); end
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      checks++; if (bus.ir_valid !== 1'b0 || bus.rom_en !== 1'b0)
        begin errors++; $display("FAIL halt_idle_%0d got v=%b en=%b exp 0/0", i, bus.ir_valid, bus.rom_en); end
    end
    bus.halt = 1'b0; #1;
    checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 32'h28)
      begin errors++; $display("FAIL halt_resume got en=%b addr=%h exp 1/00000028", bus.rom_en, bus.rom_addr); end
    tick(); #1;
    checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h28 || bus.ir_data !== 32'h1000000a || bus.misalign !== 1'b1)
      begin errors++; $display("FAIL halt_next got v=%b pc=%h d=%h m=%b exp 1/00000028/1000000a/1", bus.ir_valid, bus.ir_pc, bus.ir_data, bus.misalign); end
  endtask

  // Redirect to the top word: PC wraps to 0 and the ROM aliases on [9:2].
  task automatic test_wrap;
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; #1;
    tick(); bus.redirect = 1'b0; #1;
    checks++; if (bus.ir_pc !== 32'hFFFF_FFFC || bus.ir_data !== 32'hdeadbeef || bus.rom_addr !== 32'h0)
      begin errors++; $display("FAIL wrap_top got pc=%h d=%h addr=%h exp fffffffc/deadbeef/00000000", bus.ir_pc, bus.ir_data, bus.rom_addr); end
    tick(); #1;
    checks++; if (bus.ir_pc !== 32'h0 || bus.ir_data !== 32'h40000113)
      begin errors++; $display("FAIL wrap_zero got pc=%h d=%h exp 00000000/40000113", bus.ir_pc, bus.ir_data); end
  endtask

  // Reset pulsed mid-stall: everything restarts as after the first reset.
  task automatic test_reset_mid_stall;
    tick(); bus.ir_ready = 1'b0; #1;
    tick(); #1;
    test_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h40000113; mem[1] = 32'hfe010113; mem[2] = 32'h00812e23;
    mem[3] = 32'hfe010413; mem[7] = 32'hfec42703; mem[255] = 32'hdeadbeef;
    test_reset();
    test_stall();
    test_redirect();
    test_misalign();
    test_halt();
    test_wrap();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
